// File: rtl/mock_fe_trace_if.sv
// Bundles the three handshake channels of the mock front end: the fetch
// message toward the FE queue FIFO, the command from the back end, and the
// record/echo pair with the trace-replay node.
//
// Handshake rules, identical on every channel:
//   *_v  / *_ready : a transfer happens on a rising edge where both are 1.
//                    The producer holds data stable while v=1 and ready=0.
//                    The FE queue output is ready-then-valid: fe_queue_v_o is
//                    asserted only while fe_queue_ready_i is 1.
//   *_v  / *_yumi  : the consumer raises yumi only when v is 1, and the
//                    transfer happens on that edge.
//
// Field layouts (LSB first):
//   fe_queue : [M-1:0] branch_metadata_fwd, [M+31:M] instr,
//              [M+32+V-1:M+32] pc, [MSB] msg_type (0 = e_fe_fetch)
//   fe_cmd   : [V-1:0] pc, [V+2:V] opcode, remaining bits are operands
//   trace in : [31:0] instr, [V+31:32] pc, upper bits ignored
//   trace out: [V-1:0] pc operand, [V+2:V] opcode, upper bits 0
interface mock_fe_trace_if #(
  parameter int vaddr_width_p               = 39,
  parameter int paddr_width_p               = 56,
  parameter int asid_width_p                = 10,
  parameter int branch_metadata_fwd_width_p = 8,
  parameter int trace_ring_width_p          = 72
);
  localparam int fe_queue_width_lp = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p;
  localparam int fe_cmd_width_lp   = 3 + vaddr_width_p + paddr_width_p + asid_width_p
                                     + branch_metadata_fwd_width_p;

  logic [fe_queue_width_lp-1:0]  fe_queue_o;
  logic                          fe_queue_v_o;
  logic                          fe_queue_ready_i;
  logic [fe_cmd_width_lp-1:0]    fe_cmd_i;
  logic                          fe_cmd_v_i;
  logic                          fe_cmd_yumi_o;
  logic [trace_ring_width_p-1:0] trace_data_i;
  logic                          trace_v_i;
  logic                          trace_yumi_o;
  logic [trace_ring_width_p-1:0] trace_data_o;
  logic                          trace_v_o;
  logic                          trace_ready_i;

  // Mock front end side
  modport master (
    output fe_queue_o, fe_queue_v_o, input fe_queue_ready_i,
    input  fe_cmd_i, fe_cmd_v_i, output fe_cmd_yumi_o,
    input  trace_data_i, trace_v_i, output trace_yumi_o,
    output trace_data_o, trace_v_o, input trace_ready_i
  );

  // Back end / FIFO / trace node side
  modport slave (
    input  fe_queue_o, fe_queue_v_o, output fe_queue_ready_i,
    output fe_cmd_i, fe_cmd_v_i, input fe_cmd_yumi_o,
    output trace_data_i, trace_v_i, input trace_yumi_o,
    input  trace_data_o, trace_v_o, output trace_ready_i
  );
endinterface

// File: rtl/mock_fe_trace.sv
// Trace-driven front end stand-in. Pulls (pc, instr) records from the trace
// node, presents each as a fetch message, and lets back-end commands squash
// the held record; every accepted command is echoed back to the trace node.
// Record continuity is checked against the expected next pc (sticky error).
module mock_fe_trace #(
  parameter int vaddr_width_p               = 39,
  parameter int paddr_width_p               = 56,
  parameter int asid_width_p                = 10,
  parameter int branch_metadata_fwd_width_p = 8,
  parameter int trace_ring_width_p          = 72,
  parameter logic [vaddr_width_p-1:0] bp_first_pc_p = vaddr_width_p'(32'h8000_0000)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  mock_fe_trace_if.master bus,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] squash_cnt_o,
  output logic        error_o,
  output logic [1:0]  dbg_state_o
);
  localparam int V  = vaddr_width_p;
  localparam int M  = branch_metadata_fwd_width_p;
  localparam int QW = 1 + V + 32 + M;
  localparam int CW = 3 + V + paddr_width_p + asid_width_p + M;

  localparam logic [2:0] OP_STATE_RESET = 3'd0;
  localparam logic [2:0] OP_PC_REDIRECT = 3'd1;

  typedef enum logic [1:0] {e_wait = 2'd0, e_emit = 2'd1, e_report = 2'd2} state_e;

  state_e                  r_state, w_state_n;
  logic [V-1:0]            r_pc, r_exp_pc, r_cmd_pc;
  logic [31:0]             r_instr, r_fetch_cnt, r_squash_cnt;
  logic [2:0]              r_op;
  logic                    r_error;

  logic [CW-1:0]           w_cmd;
  logic [V-1:0]            w_cmd_pc, w_trace_pc;
  logic [2:0]              w_cmd_op;
  logic [31:0]             w_trace_instr;
  logic                    w_cmd_yumi, w_trace_yumi, w_fetch_v;
  logic [QW-1:0]           w_fe_queue;
  logic [trace_ring_width_p-1:0] w_echo;

  assign w_cmd         = bus.fe_cmd_i;
  assign w_cmd_pc      = w_cmd[V-1:0];
  assign w_cmd_op      = w_cmd[V+2:V];
  assign w_trace_instr = bus.trace_data_i[31:0];
  assign w_trace_pc    = bus.trace_data_i[V+31:32];

  // Command operands and spare trace bits carry nothing this block needs.
  wire w_unused = ^{w_cmd, bus.trace_data_i};

  // Next state and handshakes; a pending command beats trace consume and fetch emit.
  always_comb begin
    w_state_n    = r_state;
    w_cmd_yumi   = 1'b0;
    w_trace_yumi = 1'b0;
    w_fetch_v    = 1'b0;
    case (r_state)
      e_wait: begin
        w_cmd_yumi   = bus.fe_cmd_v_i;
        w_trace_yumi = bus.trace_v_i & ~bus.fe_cmd_v_i;
        if (bus.fe_cmd_v_i)     w_state_n = e_report;
        else if (bus.trace_v_i) w_state_n = e_emit;
      end
      e_emit: begin
        w_cmd_yumi = bus.fe_cmd_v_i;
        w_fetch_v  = bus.fe_queue_ready_i & ~bus.fe_cmd_v_i;
        if (bus.fe_cmd_v_i)            w_state_n = e_report;
        else if (bus.fe_queue_ready_i) w_state_n = e_wait;
      end
      e_report: begin
        if (bus.trace_ready_i) w_state_n = e_wait;
      end
      default: w_state_n = e_wait;
    endcase
    if (reset_i) begin
      w_cmd_yumi   = 1'b0;
      w_trace_yumi = 1'b0;
      w_fetch_v    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_wait;
    else         r_state <= w_state_n;
  end

  // Held record, latched command, expected pc, counters and sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc         <= '0;
      r_instr      <= '0;
      r_cmd_pc     <= '0;
      r_op         <= '0;
      r_exp_pc     <= bp_first_pc_p;
      r_fetch_cnt  <= '0;
      r_squash_cnt <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_trace_yumi) begin
        r_pc    <= w_trace_pc;
        r_instr <= w_trace_instr;
        if (w_trace_pc != r_exp_pc) r_error <= 1'b1;
      end
      if (w_fetch_v) begin
        r_exp_pc <= r_pc + V'(4);
        if (r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_cmd_yumi) begin
        r_cmd_pc <= w_cmd_pc;
        r_op     <= w_cmd_op;
        // A held record is thrown away and must be replayed by the trace.
        if (r_state == e_emit && r_squash_cnt != 32'hFFFF_FFFF)
          r_squash_cnt <= r_squash_cnt + 32'd1;
        if (w_cmd_op == OP_PC_REDIRECT || w_cmd_op == OP_STATE_RESET)
          r_exp_pc <= w_cmd_pc;
      end
    end
  end

  // Fetch message and command echo assembly.
  always_comb begin
    w_fe_queue                = '0;
    w_fe_queue[M+31:M]        = r_instr;
    w_fe_queue[M+32+V-1:M+32] = r_pc;
    w_fe_queue[QW-1]          = 1'b0;  // e_fe_fetch
    w_echo                    = '0;
    w_echo[V-1:0]             = r_cmd_pc;
    w_echo[V+2:V]             = r_op;
  end

  assign bus.fe_queue_o    = w_fe_queue;
  assign bus.fe_queue_v_o  = w_fetch_v;
  assign bus.fe_cmd_yumi_o = w_cmd_yumi;
  assign bus.trace_yumi_o  = w_trace_yumi;
  assign bus.trace_data_o  = w_echo;
  assign bus.trace_v_o     = (r_state == e_report);

  assign fetch_cnt_o  = r_fetch_cnt;
  assign squash_cnt_o = r_squash_cnt;
  assign error_o      = r_error;
  assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_mock_fe_trace.sv
// Bench for mock_fe_trace: directed steps followed by a random phase, all
// checked cycle by cycle against a transaction-level model of the mock FE.
module tb_mock_fe_trace;
  localparam int V  = 39;
  localparam int P  = 56;
  localparam int A  = 10;
  localparam int M  = 8;
  localparam int T  = 72;
  localparam int QW = 1 + V + 32 + M;
  localparam int OW = P + A + M;
  localparam logic [V-1:0] FIRST = 39'h00_8000_0000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] fetch_cnt_o, squash_cnt_o;
  logic        error_o;
  logic [1:0]  dbg_state_o;
  int          total = 0;
  int          bad   = 0;

  // Model: records taken but not yet delivered, commands not yet echoed.
  logic [QW-1:0] exp_q[$];
  logic [T-1:0]  echo_q[$];
  logic [V-1:0]  m_exp_pc, m_held_pc;
  logic [31:0]   m_fetch, m_squash;
  logic          m_err;

  mock_fe_trace_if #(.vaddr_width_p(V), .paddr_width_p(P), .asid_width_p(A),
                     .branch_metadata_fwd_width_p(M), .trace_ring_width_p(T)) fe_if ();

  mock_fe_trace #(.vaddr_width_p(V), .paddr_width_p(P), .asid_width_p(A),
                  .branch_metadata_fwd_width_p(M), .trace_ring_width_p(T),
                  .bp_first_pc_p(FIRST)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(fe_if),
    .fetch_cnt_o(fetch_cnt_o), .squash_cnt_o(squash_cnt_o),
    .error_o(error_o), .dbg_state_o(dbg_state_o));

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic drive_trace(input logic v, input logic [V-1:0] pc, input logic [31:0] instr);
    fe_if.trace_v_i    = v;
    fe_if.trace_data_i = {1'($urandom()), pc, instr};
  endtask

  task automatic drive_cmd(input logic v, input logic [2:0] op, input logic [V-1:0] pc);
    fe_if.fe_cmd_v_i = v;
    fe_if.fe_cmd_i   = {OW'({$urandom(), $urandom(), $urandom()}), op, pc};
  endtask

  task automatic quiet_inputs();
    drive_trace(1'b0, '0, '0);
    drive_cmd(1'b0, 3'd0, '0);
    fe_if.fe_queue_ready_i = 1'b1;
    fe_if.trace_ready_i    = 1'b1;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model,
  // then step to just after the next rising edge.
  task automatic tick();
    logic e_cmd_y, e_tr_y, e_q_v, e_tr_v;
    logic [V-1:0] pc, cpc;
    logic [2:0] op;
    #4;
    e_tr_v  = (echo_q.size() != 0);
    e_cmd_y = !reset_i && fe_if.fe_cmd_v_i && !e_tr_v;
    e_tr_y  = !reset_i && fe_if.trace_v_i && !fe_if.fe_cmd_v_i && !e_tr_v && exp_q.size() == 0;
    e_q_v   = !reset_i && exp_q.size() != 0 && fe_if.fe_queue_ready_i && !fe_if.fe_cmd_v_i && !e_tr_v;
    check("fe_cmd_yumi", fe_if.fe_cmd_yumi_o, e_cmd_y);
    check("trace_yumi", fe_if.trace_yumi_o, e_tr_y);
    check("fe_queue_v", fe_if.fe_queue_v_o, e_q_v);
    if (!reset_i) begin
      check("trace_v", fe_if.trace_v_o, e_tr_v);
      check("fetch_cnt", fetch_cnt_o, m_fetch);
      check("squash_cnt", squash_cnt_o, m_squash);
      check("error", error_o, m_err);
      if (e_tr_v) check("echo_data", fe_if.trace_data_o, echo_q[0]);
      if (exp_q.size() != 0) check("fe_queue_data", fe_if.fe_queue_o, exp_q[0]);
    end
    if (reset_i) begin
      exp_q.delete(); echo_q.delete();
      m_exp_pc = FIRST; m_fetch = '0; m_squash = '0; m_err = 1'b0;
    end else begin
      if (e_tr_y) begin
        pc = fe_if.trace_data_i[V+31:32];
        if (pc != m_exp_pc) m_err = 1'b1;
        m_held_pc = pc;
        exp_q.push_back({1'b0, pc, fe_if.trace_data_i[31:0], {M{1'b0}}});
      end
      if (e_q_v) begin
        void'(exp_q.pop_front());
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        m_exp_pc = m_held_pc + V'(4);
      end
      if (e_cmd_y) begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          if (m_squash != 32'hFFFF_FFFF) m_squash++;
        end
        op  = fe_if.fe_cmd_i[V+2:V];
        cpc = fe_if.fe_cmd_i[V-1:0];
        if (op == 3'd0 || op == 3'd1) m_exp_pc = cpc;
        echo_q.push_back(T'({op, cpc}));
      end
      if (e_tr_v && fe_if.trace_ready_i) void'(echo_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    quiet_inputs();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Offer one record, then let it be emitted.
  task automatic feed_one(input logic [V-1:0] pc);
    drive_trace(1'b1, pc, $urandom());
    tick();
    drive_trace(1'b0, '0, '0);
    tick();
  endtask

  localparam logic [V-1:0] TOP = {V{1'b1}} - V'(3);

  initial begin
    do_reset();
    check("reset_fetch_cnt", fetch_cnt_o, 32'd0);
    check("reset_error", error_o, 1'b0);
    check("reset_trace_v", fe_if.trace_v_o, 1'b0);

    // Three sequential records, ready always high.
    for (int i = 0; i < 3; i++) feed_one(FIRST + V'(4 * i));
    check("t1_fetch_cnt", fetch_cnt_o, 32'd3);
    check("t1_error", error_o, 1'b0);

    // FE queue back-pressure while holding a record.
    drive_trace(1'b1, FIRST + V'(12), 32'hdead_beef);
    fe_if.fe_queue_ready_i = 1'b0;
    tick();
    drive_trace(1'b0, '0, '0);
    repeat (5) tick();
    fe_if.fe_queue_ready_i = 1'b1;
    tick();
    check("t2_fetch_cnt", fetch_cnt_o, 32'd4);

    // Redirect while holding a record: squash, echo, replay from new pc.
    drive_trace(1'b1, FIRST + V'(16), 32'h1234_5678);
    tick();
    drive_trace(1'b0, '0, '0);
    drive_cmd(1'b1, 3'd1, V'(32'h8000_0100));
    tick();
    drive_cmd(1'b0, 3'd0, '0);
    check("t3_trace_v", fe_if.trace_v_o, 1'b1);
    check("t3_echo", fe_if.trace_data_o, T'({3'd1, V'(32'h8000_0100)}));
    tick();
    check("t3_squash_cnt", squash_cnt_o, 32'd1);
    feed_one(V'(32'h8000_0100));
    check("t3_error", error_o, 1'b0);

    // Command and record together in e_wait: command wins.
    drive_trace(1'b1, V'(32'h8000_0104), 32'h0bad_f00d);
    drive_cmd(1'b1, 3'd4, V'($urandom()));
    tick();
    drive_cmd(1'b0, 3'd0, '0);
    tick();
    tick();
    drive_trace(1'b0, '0, '0);
    tick();
    check("t4_fetch_cnt", fetch_cnt_o, 32'd6);

    // Echo held under trace back-pressure; further commands refused.
    fe_if.trace_ready_i = 1'b0;
    drive_cmd(1'b1, 3'd2, V'(32'h0000_4444));
    tick();
    drive_cmd(1'b1, 3'd1, V'(32'h0000_8888));
    repeat (4) tick();
    drive_cmd(1'b0, 3'd0, '0);
    fe_if.trace_ready_i = 1'b1;
    tick();

    // Expected pc wraps at the top of the virtual address space.
    drive_cmd(1'b1, 3'd0, TOP);
    tick();
    drive_cmd(1'b0, 3'd0, '0);
    tick();
    feed_one(TOP);
    feed_one('0);
    check("t6_error", error_o, 1'b0);

    // Random traffic; the trace always offers the model's expected pc.
    for (int c = 0; c < 3000; c++) begin
      fe_if.fe_queue_ready_i = ($urandom_range(0, 3) != 0);
      fe_if.trace_ready_i    = ($urandom_range(0, 2) != 0);
      drive_trace(1'($urandom_range(0, 1)), m_exp_pc, $urandom());
      if ($urandom_range(0, 9) == 0) drive_cmd(1'b1, 3'($urandom_range(0, 7)), V'({$urandom(), $urandom()}));
      else                           drive_cmd(1'b0, 3'd0, '0);
      tick();
    end
    quiet_inputs();
    repeat (4) tick();
    check("rand_error", error_o, 1'b0);

    // Continuity error, sticky, then reset while reporting.
    do_reset();
    drive_trace(1'b1, FIRST + V'(8), 32'h5555_aaaa);
    tick();
    check("t8_error_set", error_o, 1'b1);
    drive_trace(1'b0, '0, '0);
    tick();
    feed_one(FIRST + V'(12));
    fe_if.trace_ready_i = 1'b0;
    drive_cmd(1'b1, 3'd4, V'(32'h0000_0010));
    tick();
    drive_cmd(1'b0, 3'd0, '0);
    tick();
    check("t8_error_held", error_o, 1'b1);
    reset_i = 1'b1;
    drive_trace(1'b1, FIRST, 32'h0);
    drive_cmd(1'b1, 3'd1, FIRST);
    tick();
    reset_i = 1'b0;
    quiet_inputs();
    check("t8_rst_trace_v", fe_if.trace_v_o, 1'b0);
    check("t8_rst_error", error_o, 1'b0);
    check("t8_rst_fetch_cnt", fetch_cnt_o, 32'd0);
    check("t8_rst_squash_cnt", squash_cnt_o, 32'd0);
    feed_one(FIRST);
    check("t8_first_ok", error_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
